gnn_act_stage: RTL and testbench

- Parametrised, pipelined activation stage for the GNN datapath.
- Applies a run-time-selectable activation (bypass, ReLU, leaky ReLU, clipped ReLU) to NODES x FEATS signed lanes per beat, then saturates to OUT_W bits.
- Sits between the aggregation/combination outputs and the next layer's feature buffer.
- Uses a valid/ready handshake with full-throughput backpressure, per-beat non-zero counts and a frame-completion pulse for sparsity-aware downstream scheduling.

---
 rtl/gnn_act_stage_if.sv | 49 ++++
 rtl/gnn_act_stage.sv | 185 ++++++++++++++++++
 tb/tb_gnn_act_stage.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gnn_act_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : gnn_act_stage_if                                              |
// | Purpose  : Handshake and data bundle for the GNN activation stage.       |
// |            Carries the upstream beat (valid/ready, lanes, mode, clip)    |
// |            and the downstream beat (valid/ready, lanes, nz count, frame  |
// |            completion pulse).                                            |
// | Modports : slave  - the activation stage itself                          |
// |            master - the upstream producer / downstream consumer pair     |
// | Signals  : in_valid, in_ready, in_data, in_mode, clip_val,               |
// |            out_valid, out_ready, out_data, out_nz_cnt, frame_done        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface gnn_act_stage_if #(
  parameter int DATA_W = 21,
  parameter int OUT_W  = 21,
  parameter int NODES  = 4,
  parameter int FEATS  = 4
) ();

  localparam int c_lanes = NODES * FEATS;
  localparam int c_cnt_w = $clog2(c_lanes + 1);

  // Upstream side
  logic                        in_valid;
  logic                        in_ready;
  logic [c_lanes*DATA_W-1:0]   in_data;
  logic [1:0]                  in_mode;
  logic [OUT_W-1:0]            clip_val;

  // Downstream side
  logic                        out_valid;
  logic                        out_ready;
  logic [c_lanes*OUT_W-1:0]    out_data;
  logic [c_cnt_w-1:0]          out_nz_cnt;
  logic                        frame_done;

  modport slave (
    input  in_valid, in_data, in_mode, clip_val, out_ready,
    output in_ready, out_valid, out_data, out_nz_cnt, frame_done
  );

  modport master (
    output in_valid, in_data, in_mode, clip_val, out_ready,
    input  in_ready, out_valid, out_data, out_nz_cnt, frame_done
  );

endinterface
`default_nettype wire

// File: rtl/gnn_act_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : gnn_act_stage                                                 |
// | Purpose  : Two-stage pipelined activation for the GNN datapath.          |
// |            S1 applies a per-beat activation (bypass / ReLU / leaky ReLU /|
// |            clipped ReLU) to NODES*FEATS signed lanes on DATA_W+1 bits.   |
// |            S2 saturates each lane to OUT_W bits, counts non-zero lanes   |
// |            and flags the beat that completes a FRAME_BEATS-beat frame.   |
// | Ports    : clk    - rising-edge clock                                    |
// |            rst_n  - asynchronous active-low reset                        |
// |            bus    - gnn_act_stage_if.slave (in_* beat, out_* beat)       |
// | Limits   : 2 <= OUT_W <= DATA_W, 1 <= LEAK_SH < DATA_W,                  |
// |            FRAME_BEATS >= 1; interface parameters must match.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module gnn_act_stage #(
  parameter int DATA_W      = 21,
  parameter int OUT_W       = 21,
  parameter int NODES       = 4,
  parameter int FEATS       = 4,
  parameter int LEAK_SH     = 3,
  parameter int FRAME_BEATS = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  gnn_act_stage_if.slave bus
);

  localparam int c_lanes  = NODES * FEATS;
  localparam int c_ext_w  = DATA_W + 1;
  localparam int c_cnt_w  = $clog2(c_lanes + 1);
  localparam int c_bcnt_w = $clog2(FRAME_BEATS + 1);

  localparam logic [1:0] c_mode_bypass = 2'd0;
  localparam logic [1:0] c_mode_relu   = 2'd1;
  localparam logic [1:0] c_mode_leaky  = 2'd2;
  localparam logic [1:0] c_mode_clip   = 2'd3;

  // Saturation bounds expressed on the extended activation width.
  localparam logic signed [c_ext_w-1:0] c_sat_max =
    {{(DATA_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [c_ext_w-1:0] c_sat_min =
    {{(DATA_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

  localparam logic [c_bcnt_w-1:0] c_last_beat = c_bcnt_w'(FRAME_BEATS - 1);

  // ---------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------
  logic                         r_s1_valid;
  logic [c_lanes*c_ext_w-1:0]   r_s1_act;
  logic                         r_s2_valid;
  logic [c_lanes*OUT_W-1:0]     r_s2_data;
  logic [c_cnt_w-1:0]           r_s2_nz;
  logic                         r_s2_frame_done;
  logic [c_bcnt_w-1:0]          r_beat_cnt;

  // ---------------------------------------------------------------------
  // Combinational datapath and flow control
  // ---------------------------------------------------------------------
  logic                         w_s1_adv;
  logic                         w_s2_adv;
  logic                         w_out_xfer;
  logic [c_bcnt_w-1:0]          w_bcnt_next;
  logic signed [c_ext_w-1:0]    w_clip_ext;
  logic [c_lanes*c_ext_w-1:0]   w_act;
  logic [c_lanes*OUT_W-1:0]     w_sat;
  logic [c_lanes-1:0]           w_nz;
  logic [c_cnt_w-1:0]           w_nz_cnt;

  // S2 frees up when empty or draining; S1 frees up when empty or when it
  // can hand its beat to S2. in_ready is therefore the only path that is
  // combinational from out_ready.
  assign w_s2_adv   = !r_s2_valid || bus.out_ready;
  assign w_s1_adv   = !r_s1_valid || w_s2_adv;
  assign w_out_xfer = r_s2_valid && bus.out_ready;

  // Clip ceiling is unsigned, so zero-extend it; it is then always a
  // non-negative value on the extended signed width.
  assign w_clip_ext = {{(c_ext_w - OUT_W){1'b0}}, bus.clip_val};

  for (genvar k = 0; k < c_lanes; k++) begin : g_lane
    logic signed [DATA_W-1:0]  w_x;
    logic signed [c_ext_w-1:0] w_xe;
    logic signed [c_ext_w-1:0] w_leak;
    logic signed [c_ext_w-1:0] w_y;
    logic signed [c_ext_w-1:0] w_s;
    logic [OUT_W-1:0]          w_o;

    assign w_x    = bus.in_data[k*DATA_W +: DATA_W];
    assign w_xe   = {w_x[DATA_W-1], w_x};
    // Arithmetic shift floors toward -inf, so small negatives settle at -1.
    assign w_leak = w_xe >>> LEAK_SH;

    always_comb begin
      w_y = w_xe;
      case (bus.in_mode)
        c_mode_bypass: w_y = w_xe;
        c_mode_relu:   w_y = w_xe[c_ext_w-1] ? '0 : w_xe;
        c_mode_leaky:  w_y = w_xe[c_ext_w-1] ? w_leak : w_xe;
        c_mode_clip:   w_y = w_xe[c_ext_w-1] ? '0 :
                             ((w_xe > w_clip_ext) ? w_clip_ext : w_xe);
      endcase
    end

    assign w_act[k*c_ext_w +: c_ext_w] = w_y;

    // Saturation works on the registered S1 lane.
    assign w_s = r_s1_act[k*c_ext_w +: c_ext_w];

    always_comb begin
      if (w_s > c_sat_max) begin
        w_o = c_sat_max[OUT_W-1:0];
      end else if (w_s < c_sat_min) begin
        w_o = c_sat_min[OUT_W-1:0];
      end else begin
        w_o = w_s[OUT_W-1:0];
      end
    end

    assign w_sat[k*OUT_W +: OUT_W] = w_o;
    assign w_nz[k]                 = |w_o;
  end

  always_comb begin
    w_nz_cnt = '0;
    for (int i = 0; i < c_lanes; i++) begin
      w_nz_cnt = w_nz_cnt + c_cnt_w'(w_nz[i]);
    end
  end

  // Beat count after any output transfer happening this cycle. A beat
  // loaded into S2 now is transfer number w_bcnt_next of the frame, so it
  // completes the frame when that index is the last one.
  assign w_bcnt_next = w_out_xfer ?
                       ((r_beat_cnt == c_last_beat) ? '0 : r_beat_cnt + c_bcnt_w'(1)) :
                       r_beat_cnt;

  // ---------------------------------------------------------------------
  // S1: activation register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_act   <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_act <= w_act;
      end
    end
  end

  // ---------------------------------------------------------------------
  // S2: saturation, non-zero count, frame tracking
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid      <= 1'b0;
      r_s2_data       <= '0;
      r_s2_nz         <= '0;
      r_s2_frame_done <= 1'b0;
      r_beat_cnt      <= '0;
    end else begin
      r_beat_cnt <= w_bcnt_next;
      if (w_s2_adv) begin
        r_s2_valid      <= r_s1_valid;
        // Cleared when S2 empties so the flag never lingers on an idle bus.
        r_s2_frame_done <= r_s1_valid && (w_bcnt_next == c_last_beat);
        if (r_s1_valid) begin
          r_s2_data <= w_sat;
          r_s2_nz   <= w_nz_cnt;
        end
      end
    end
  end

  assign bus.in_ready   = w_s1_adv;
  assign bus.out_valid  = r_s2_valid;
  assign bus.out_data   = r_s2_data;
  assign bus.out_nz_cnt = r_s2_nz;
  assign bus.frame_done = r_s2_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_gnn_act_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_gnn_act_stage                                              |
// | Purpose  : Self-checking bench for gnn_act_stage. Two instances run in   |
// |            lockstep on shared stimulus: OUT_W=21 and OUT_W=16.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_gnn_act_stage;

  localparam int LANES = 16;
  localparam int W_A   = 21;
  localparam int W_B   = 16;
  localparam int VEC_A = LANES * W_A;
  localparam int VEC_B = LANES * W_B;
  localparam int FRAME = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic             tb_valid = 1'b0;
  logic [VEC_A-1:0] tb_data  = '0;
  logic [1:0]       tb_mode  = '0;
  logic [W_A-1:0]   tb_clip  = '0;
  logic             tb_ready = 1'b1;

  gnn_act_stage_if #(.DATA_W(21), .OUT_W(W_A), .NODES(4), .FEATS(4)) bus_a ();
  gnn_act_stage_if #(.DATA_W(21), .OUT_W(W_B), .NODES(4), .FEATS(4)) bus_b ();

  assign bus_a.in_valid  = tb_valid;
  assign bus_a.in_data   = tb_data;
  assign bus_a.in_mode   = tb_mode;
  assign bus_a.clip_val  = tb_clip;
  assign bus_a.out_ready = tb_ready;
  assign bus_b.in_valid  = tb_valid;
  assign bus_b.in_data   = tb_data;
  assign bus_b.in_mode   = tb_mode;
  assign bus_b.clip_val  = tb_clip[W_B-1:0];
  assign bus_b.out_ready = tb_ready;

  gnn_act_stage #(.DATA_W(21), .OUT_W(W_A), .NODES(4), .FEATS(4),
                  .LEAK_SH(3), .FRAME_BEATS(FRAME))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

  gnn_act_stage #(.DATA_W(21), .OUT_W(W_B), .NODES(4), .FEATS(4),
                  .LEAK_SH(3), .FRAME_BEATS(FRAME))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk_vec(input string name, input logic [VEC_A-1:0] got,
                         input logic [VEC_A-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference activation + saturation with LEAK_SH=3.
  function automatic int act_model(int x, int mode, int clip, int ow);
    int y, hi, lo;
    case (mode)
      0:       y = x;
      1:       y = (x < 0) ? 0 : x;
      2:       y = (x < 0) ? -((-x + 7) / 8) : x;
      default: y = (x < 0) ? 0 : ((x > clip) ? clip : x);
    endcase
    hi = (1 << (ow - 1)) - 1;
    lo = -(1 << (ow - 1));
    if (y > hi) y = hi;
    if (y < lo) y = lo;
    return y;
  endfunction

  typedef struct {
    logic [VEC_A-1:0] ea;
    logic [VEC_B-1:0] eb;
    int               nza;
    int               nzb;
    int               acc;
    bit               lat;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    int mode;
    int clip;
    int x[8];
    int ea[8];
    int eb[8];
  } vec_t;

  vec_t tbl[6];

  // ---------------------------------------------------------------------
  // Output monitor / scoreboard
  // ---------------------------------------------------------------------
  int   xfers  = 0;
  int   fd_cnt = 0;
  bit   prev_stall = 1'b0;
  bit   fd_exp;
  exp_t cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (tb_ready) chk("in_ready_open", bus_a.in_ready, 1);
      if (prev_stall) chk("stall_valid_held", bus_a.out_valid, 1);
      if (bus_a.out_valid) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got out_valid=1, expected no beat (t=%0t)", $time);
        end else begin
          cur    = sb[0];
          fd_exp = ((xfers % FRAME) == FRAME - 1);
          chk_vec("data_a", bus_a.out_data, cur.ea);
          chk_vec("data_b", VEC_A'(bus_b.out_data), VEC_A'(cur.eb));
          chk("valid_b", bus_b.out_valid, 1);
          chk("nz_a", bus_a.out_nz_cnt, cur.nza);
          chk("nz_b", bus_b.out_nz_cnt, cur.nzb);
          chk("frame_done_a", bus_a.frame_done, fd_exp);
          chk("frame_done_b", bus_b.frame_done, fd_exp);
          if (tb_ready) begin
            if (cur.lat) chk("latency", cyc - cur.acc + 1, 2);
            if (bus_a.frame_done) fd_cnt++;
            xfers++;
            void'(sb.pop_front());
          end
        end
      end
      prev_stall = bus_a.out_valid && !tb_ready;
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  task automatic send(input logic [1:0] mode, input logic [W_A-1:0] clip,
                      input logic [VEC_A-1:0] data, input exp_t e);
    bit acc;
    int waited;
    acc    = 1'b0;
    waited = 0;
    tb_valid = 1'b1;
    tb_mode  = mode;
    tb_clip  = clip;
    tb_data  = data;
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = bus_a.in_ready;
      @(posedge clk);
      waited++;
    end
    #1;
    tb_valid = 1'b0;
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got no in_ready in %0d cycles, expected acceptance", waited);
    end else begin
      e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic send_rand(input int mode);
    exp_t             e;
    logic [VEC_A-1:0] d;
    int               x, ya, yb, clip;
    clip  = int'($urandom_range(0, 32767));
    e.ea  = '0;
    e.eb  = '0;
    e.nza = 0;
    e.nzb = 0;
    e.acc = 0;
    e.lat = 1'b0;
    d     = '0;
    for (int k = 0; k < LANES; k++) begin
      x  = int'($urandom_range(0, 2097151)) - 1048576;
      ya = act_model(x, mode, clip, W_A);
      yb = act_model(x, mode, clip, W_B);
      d[k*W_A +: W_A]    = W_A'(x);
      e.ea[k*W_A +: W_A] = W_A'(ya);
      e.eb[k*W_B +: W_B] = W_B'(yb);
      if (ya != 0) e.nza++;
      if (yb != 0) e.nzb++;
    end
    send(2'(mode), W_A'(clip), d, e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_queue_empty", sb.size(), 0);
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, releases away
  // from the clock edge and returns just after the first live edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid_a", bus_a.out_valid, 0);
    chk("rst_out_valid_b", bus_b.out_valid, 0);
    chk_vec("rst_out_data_a", bus_a.out_data, '0);
    chk("rst_nz_a", bus_a.out_nz_cnt, 0);
    chk("rst_frame_done_a", bus_a.frame_done, 0);
    sb.delete();
    xfers  = 0;
    fd_cnt = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_reset", bus_a.in_ready, 1);
  endtask

  logic [VEC_A-1:0] v_data;
  exp_t             v_e;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by t=%0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{1, 0,
               '{-5, 0, 7, 1048575, -1048576, 3, -2, 200000},
               '{0, 0, 7, 1048575, 0, 3, 0, 200000},
               '{0, 0, 7, 32767, 0, 3, 0, 32767}};
    tbl[1] = '{2, 0,
               '{-80, -1, -7, 40, -1048576, 1048575, -8, 0},
               '{-10, -1, -1, 40, -131072, 1048575, -1, 0},
               '{-10, -1, -1, 40, -32768, 32767, -1, 0}};
    tbl[2] = '{3, 100,
               '{-3, 50, 100, 250, 0, 101, -1048576, 1048575},
               '{0, 50, 100, 100, 0, 100, 0, 100},
               '{0, 50, 100, 100, 0, 100, 0, 100}};
    tbl[3] = '{0, 0,
               '{40000, -40000, 32767, -32768, 1048575, -1048576, 1, -1},
               '{40000, -40000, 32767, -32768, 1048575, -1048576, 1, -1},
               '{32767, -32768, 32767, -32768, 32767, -32768, 1, -1}};
    tbl[4] = '{3, 0,
               '{5, -5, 0, 1000, 7, 8, 9, -9},
               '{0, 0, 0, 0, 0, 0, 0, 0},
               '{0, 0, 0, 0, 0, 0, 0, 0}};
    tbl[5] = '{3, 32767,
               '{1048575, 32767, 32768, -1, 20000, 0, 1, 2},
               '{32767, 32767, 32767, 0, 20000, 0, 1, 2},
               '{32767, 32767, 32767, 0, 20000, 0, 1, 2}};

    // Power-on reset and reset-state checks.
    do_reset();

    // Table vectors, one at a time, with latency check.
    tb_ready = 1'b1;
    for (int r = 0; r < 6; r++) begin
      v_data  = '0;
      v_e.ea  = '0;
      v_e.eb  = '0;
      v_e.nza = 0;
      v_e.nzb = 0;
      v_e.acc = 0;
      v_e.lat = 1'b1;
      for (int k = 0; k < LANES; k++) begin
        v_data[k*W_A +: W_A] = W_A'(tbl[r].x[k % 8]);
        v_e.ea[k*W_A +: W_A] = W_A'(tbl[r].ea[k % 8]);
        v_e.eb[k*W_B +: W_B] = W_B'(tbl[r].eb[k % 8]);
        if (tbl[r].ea[k % 8] != 0) v_e.nza++;
        if (tbl[r].eb[k % 8] != 0) v_e.nzb++;
      end
      send(2'(tbl[r].mode), W_A'(tbl[r].clip), v_data, v_e);
      drain();
    end

    // 20-beat stream, modes cycling 1/2/3/0, out_ready low for cycles 5..9.
    do_reset();
    fork
      begin
        for (int i = 0; i < 20; i++) send_rand((i + 1) % 4);
      end
      begin
        for (int c = 0; c < 12; c++) begin
          tb_ready = !(c >= 5 && c <= 9);
          if (!tb_ready) begin
            @(negedge clk);
            chk("in_ready_stalled", bus_a.in_ready, 0);
          end
          @(posedge clk);
          #1;
        end
        tb_ready = 1'b1;
      end
    join
    drain();
    chk("stream_transfers", xfers, 20);
    chk("stream_frame_pulses", fd_cnt, 1);

    // Reset with two beats in flight and the frame counter at 9.
    do_reset();
    for (int i = 0; i < 9; i++) send_rand(i % 4);
    drain();
    chk("pre_reset_transfers", xfers, 9);
    tb_ready = 1'b0;
    send_rand(1);
    send_rand(2);
    @(negedge clk);
    chk("inflight_valid", bus_a.out_valid, 1);
    do_reset();
    tb_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_reset_idle", bus_a.out_valid, 0);
    for (int i = 0; i < 16; i++) send_rand((i + 3) % 4);
    drain();
    chk("fresh_transfers", xfers, 16);
    chk("fresh_frame_pulses", fd_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
